aes_block_io: RTL

AES_BLOCK_IO -- requirements
Module: aes_block_io

---
 rtl/aes_block_io.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/aes_block_io.sv
// aes_block_io: 32-bit host word interface around a 128-bit AES encryption core.
// Packs four plaintext words, issues a one-cycle start, waits for the controller's
// done count, then streams the captured ciphertext back as four words.
// Optional feature: define AES_IO_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles without completion.
module aes_block_io #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  input  logic [31:0]  in_data,
  output logic         in_ready,
  output logic         encrypt_enable,
  output logic [127:0] data_in,
  input  logic [3:0]   count,
  input  logic [127:0] encrypted_out,
  output logic         out_valid,
  output logic [31:0]  out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         timeout_err
);

  localparam logic [1:0] LOAD  = 2'b00;
  localparam logic [1:0] ISSUE = 2'b01;
  localparam logic [1:0] WAIT  = 2'b10;
  localparam logic [1:0] DRAIN = 2'b11;

  // Round count value the controller shows once the ciphertext is ready.
  localparam logic [3:0] DONE_CNT = 4'b1010;

  logic [1:0]   state_q, state_d;
  logic [1:0]   in_cnt_q;
  logic [1:0]   out_cnt_q;
  logic [127:0] data_q;
  logic [127:0] result_q;
  logic [31:0]  out_word;
  logic         in_fire;
  logic         out_fire;
  logic         wait_done;
  logic         tmo_hit;

  // in_ready is also gated by n_rst so it is low for the whole reset window.
  assign in_ready       = (state_q == LOAD) && n_rst;
  assign encrypt_enable = (state_q == ISSUE);
  assign out_valid      = (state_q == DRAIN);
  assign busy           = (state_q != LOAD);
  assign data_in        = data_q;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  // The done count only matters in WAIT; elsewhere it is ignored.
  assign wait_done = (state_q == WAIT) && (count == DONE_CNT);

`ifdef AES_IO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q;
  logic          tmo_err_q;

  // Completion has priority: a timeout is only taken when done is absent.
  assign tmo_hit     = (state_q == WAIT) && (tmo_q == TW'(TIMEOUT_CYCLES - 1)) && !wait_done;
  assign timeout_err = tmo_err_q;

  // Cycle counter for WAIT, cleared in ISSUE so it starts at 0 on WAIT entry.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tmo_q <= '0;
    end else if (state_q == ISSUE) begin
      tmo_q <= '0;
    end else if (state_q == WAIT) begin
      tmo_q <= tmo_q + TW'(1);
    end
  end

  // One-cycle abort pulse, raised on the edge that returns the FSM to LOAD.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tmo_err_q <= 1'b0;
    end else begin
      tmo_err_q <= tmo_hit;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state logic for the LOAD -> ISSUE -> WAIT -> DRAIN cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (in_fire && (in_cnt_q == 2'd3)) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT: begin
        if (wait_done) begin
          state_d = DRAIN;
        end else if (tmo_hit) begin
          state_d = LOAD;
        end
      end
      DRAIN:   if (out_fire && (out_cnt_q == 2'd3)) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Input word counter; wraps to 0 on the 4th transfer.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      in_cnt_q <= 2'd0;
    end else if (in_fire) begin
      in_cnt_q <= in_cnt_q + 2'd1;
    end
  end

  // Plaintext packing, first word into the most significant slot; only written
  // in LOAD so data_in stays put through ISSUE, WAIT and DRAIN.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_q <= '0;
    end else if (in_fire) begin
      case (in_cnt_q)
        2'd0:    data_q[127:96] <= in_data;
        2'd1:    data_q[95:64]  <= in_data;
        2'd2:    data_q[63:32]  <= in_data;
        default: data_q[31:0]   <= in_data;
      endcase
    end
  end

  // Ciphertext capture when the controller reports done in WAIT.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      result_q <= '0;
    end else if (wait_done) begin
      result_q <= encrypted_out;
    end
  end

  // Output word counter; advances only on an accepted word so stalls hold the word.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_cnt_q <= 2'd0;
    end else if (out_fire) begin
      out_cnt_q <= out_cnt_q + 2'd1;
    end
  end

  // Ciphertext word select, most significant word first; zero outside DRAIN.
  always_comb begin
    out_word = 32'd0;
    case (out_cnt_q)
      2'd0:    out_word = result_q[127:96];
      2'd1:    out_word = result_q[95:64];
      2'd2:    out_word = result_q[63:32];
      default: out_word = result_q[31:0];
    endcase
  end

  assign out_data = out_valid ? out_word : 32'd0;

endmodule
